tsmp_key_extract: RTL

- Sits directly upstream of the TSMP MID lookup stage in the hardware control point forwarding path.
- Parses incoming frames on the 134-bit internal data bus and issues one 48-bit lookup key per frame (DMAC; MID in key[23:12]).
- Forwards frame beats unchanged to the packet buffer.
- Joins the returned 33-bit outport with the measured frame length into one forwarding descriptor per frame.

---
 rtl/tsmp_key_extract.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/tsmp_key_extract.sv
// TSMP key extraction: issues one DMAC lookup key per frame, passes beats through,
// and joins lookup result with frame length. Optional ethertype filter: TSMP_KEY_FILTER_EN.
module tsmp_key_extract #(
  parameter int TIMEOUT_CYC = 16,
  parameter int LEN_W       = 11
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_data_wr,
  input  logic [133:0]      iv_data,
  output logic              o_data_wr,
  output logic [133:0]      ov_data,
  output logic              o_tsmp_lookup_table_key_wr,
  output logic [47:0]       ov_tsmp_lookup_table_key,
  input  logic              i_tsmp_lookup_table_outport_wr,
  input  logic [32:0]       iv_tsmp_lookup_table_outport,
  output logic              o_fwd_desc_wr,
  output logic [LEN_W+32:0] ov_fwd_desc,
  output logic [15:0]       ov_timeout_cnt,
  output logic [15:0]       ov_trunc_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = '1;
  localparam logic [32:0] HOST_PORT = {1'b1, 32'h0};

  typedef enum logic [1:0] {
    IDLE_S,
    BODY_S,
    WAIT_RES_S
  } state_t;

  state_t           st_q, st_n;
  logic             flag_q, flag_n;
  logic [32:0]      port_q, port_n;
  logic [LEN_W-1:0] len_q, len_n;
  logic [TW-1:0]    tmr_q, tmr_n;
  logic             run_q, run_n;
  logic             key_wr_n, desc_wr_n;
  logic [32:0]      dport_n;
  logic [LEN_W-1:0] dlen_n;
  logic             to_inc, tr_inc;

  logic             head, tail, hit;
  logic [3:0]       inv;
  logic             cap, expire, fl_now;
  logic [32:0]      pt_now;
  logic [LEN_W:0]   acc_sum;
  logic [LEN_W-1:0] acc_len, head_len;

  assign head = i_data_wr & iv_data[133];
  assign tail = i_data_wr & iv_data[132];
  assign inv  = iv_data[131:128];

`ifdef TSMP_KEY_FILTER_EN
  assign hit = (iv_data[31:16] == 16'hFF01);
`else
  assign hit = 1'b1;
`endif

  assign head_len = tail ? LEN_W'(5'd16 - {1'b0, inv}) : LEN_W'(16);
  assign acc_sum  = {1'b0, len_q} + (LEN_W+1)'(16)
                  - (tail ? (LEN_W+1)'(inv) : '0);
  assign acc_len  = acc_sum[LEN_W] ? LEN_MAX : acc_sum[LEN_W-1:0];

  // first result wins; a running timer implies no result held yet
  assign cap    = (st_q != IDLE_S) & i_tsmp_lookup_table_outport_wr & ~flag_q;
  assign expire = run_q & (tmr_q == TW'(TIMEOUT_CYC))
                & ~i_tsmp_lookup_table_outport_wr;
  assign fl_now = flag_q | cap | expire;
  assign pt_now = flag_q ? port_q
                : (cap ? iv_tsmp_lookup_table_outport : '0);

  always_comb begin
    st_n      = st_q;
    flag_n    = flag_q;
    port_n    = port_q;
    len_n     = len_q;
    run_n     = run_q;
    tmr_n     = run_q ? tmr_q + 1'b1 : tmr_q;
    key_wr_n  = 1'b0;
    desc_wr_n = 1'b0;
    dport_n   = '0;
    dlen_n    = len_q;
    to_inc    = 1'b0;
    tr_inc    = 1'b0;
    unique case (st_q)
      IDLE_S: ;
      BODY_S: begin
        if (head) begin
          desc_wr_n = 1'b1;
          tr_inc    = 1'b1;
        end else begin
          flag_n = fl_now;
          port_n = pt_now;
          to_inc = expire;
          if (cap || expire) run_n = 1'b0;
          if (i_data_wr) len_n = acc_len;
          if (tail) begin
            if (fl_now) begin
              desc_wr_n = 1'b1;
              dport_n   = pt_now;
              dlen_n    = acc_len;
              flag_n    = 1'b0;
              st_n      = IDLE_S;
            end else begin
              st_n = WAIT_RES_S;
            end
          end
        end
      end
      WAIT_RES_S: begin
        if (fl_now) begin
          desc_wr_n = 1'b1;
          dport_n   = pt_now;
          to_inc    = expire;
          run_n     = 1'b0;
          flag_n    = 1'b0;
          st_n      = IDLE_S;
        end
      end
      default: st_n = IDLE_S;
    endcase
    // new frame: from idle, or a truncating head in the body
    if (head && st_q != WAIT_RES_S) begin
      flag_n   = ~hit;
      port_n   = hit ? '0 : HOST_PORT;
      len_n    = head_len;
      tmr_n    = '0;
      run_n    = hit;
      key_wr_n = hit;
      st_n     = tail ? WAIT_RES_S : BODY_S;
      if (tail && !hit && st_q == IDLE_S) begin
        desc_wr_n = 1'b1;
        dport_n   = HOST_PORT;
        dlen_n    = head_len;
        flag_n    = 1'b0;
        st_n      = IDLE_S;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st_q                       <= IDLE_S;
      flag_q                     <= 1'b0;
      port_q                     <= '0;
      len_q                      <= '0;
      tmr_q                      <= '0;
      run_q                      <= 1'b0;
      o_data_wr                  <= 1'b0;
      ov_data                    <= '0;
      o_tsmp_lookup_table_key_wr <= 1'b0;
      ov_tsmp_lookup_table_key   <= '0;
      o_fwd_desc_wr              <= 1'b0;
      ov_fwd_desc                <= '0;
      ov_timeout_cnt             <= '0;
      ov_trunc_cnt               <= '0;
    end else begin
      st_q                       <= st_n;
      flag_q                     <= flag_n;
      port_q                     <= port_n;
      len_q                      <= len_n;
      tmr_q                      <= tmr_n;
      run_q                      <= run_n;
      o_data_wr                  <= i_data_wr;
      ov_data                    <= iv_data;
      o_tsmp_lookup_table_key_wr <= key_wr_n;
      if (key_wr_n) ov_tsmp_lookup_table_key <= iv_data[127:80];
      o_fwd_desc_wr              <= desc_wr_n;
      if (desc_wr_n) ov_fwd_desc <= {dport_n, dlen_n};
      if (to_inc) ov_timeout_cnt <= ov_timeout_cnt + 16'd1;
      if (tr_inc) ov_trunc_cnt   <= ov_trunc_cnt + 16'd1;
    end
  end

endmodule
